// File: rtl/cm_merge_pkg.sv
// lib_cm: shared types for the cm_* streaming sort/merge blocks.
//   u32           - unsigned 32-bit type used for block parameters
//   t_merge_state - cm_merge FSM states
package lib_cm;

    typedef logic [31:0] u32;

    typedef enum logic [1:0] {
        BOTH    = 2'd0,   // both streams live, compare heads
        DRAIN_A = 2'd1,   // B packet finished, pass A through
        DRAIN_B = 2'd2    // A packet finished, pass B through
    } t_merge_state;

endpackage

// File: rtl/cm_merge_ord_chk.sv
// cm_merge_ord_chk: per-stream sort-order monitor for cm_merge.
// Remembers the last consumed element of one input stream and flags a
// consumed element that breaks the expected order within a packet.
//   clk   - clock (rising edge)
//   rst_n - asynchronous active-low reset
//   hs    - element consumed this cycle
//   data  - element value
//   last  - element closes its packet
//   viol  - combinational pulse: consumed element is out of order
module cm_merge_ord_chk
    import lib_cm::*;
#(
    parameter u32 DWIDTH = 8,
    parameter bit DESC   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hs,
    input  logic [DWIDTH-1:0] data,
    input  logic              last,
    output logic              viol
);

    logic [DWIDTH-1:0] prev;
    logic              first;
    logic              out_of_order;

    // first marks the next element as a packet start, which has no predecessor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev  <= '0;
            first <= 1'b1;
        end else if (hs) begin
            prev  <= data;
            first <= last;
        end
    end

    assign out_of_order = DESC ? (data > prev) : (data < prev);
    assign viol         = hs && !first && out_of_order;

endmodule

// File: rtl/cm_merge.sv
// cm_merge: streaming two-way merge of two sorted packets into one sorted
// packet, valid/ready on every port, registered output.
//   i_clk, i_rst_n                       - clock, async active-low reset
//   i_a_vld/o_a_rdy/i_a_data/i_a_last    - input stream A
//   i_b_vld/o_b_rdy/i_b_data/i_b_last    - input stream B
//   o_vld/i_rdy/o_data/o_last            - merged output stream
//   o_err                                - sticky: an input broke sort order
module cm_merge
    import lib_cm::*;
#(
    parameter u32 DWIDTH = 8,
    parameter bit DESC   = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_a_vld,
    output logic              o_a_rdy,
    input  logic [DWIDTH-1:0] i_a_data,
    input  logic              i_a_last,
    input  logic              i_b_vld,
    output logic              o_b_rdy,
    input  logic [DWIDTH-1:0] i_b_data,
    input  logic              i_b_last,
    output logic              o_vld,
    input  logic              i_rdy,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_last,
    output logic              o_err
);

    t_merge_state      state;
    t_merge_state      state_next;
    logic              adv;
    logic              both_vld;
    logic              sel_a;
    logic              a_hs;
    logic              b_hs;
    logic [DWIDTH-1:0] load_data;
    logic              load_last;
    logic              viol_a;
    logic              viol_b;

    // Output register can take a new element. Qualified by reset so the
    // readies stay low while reset is asserted.
    assign adv      = i_rst_n && (!o_vld || i_rdy);
    assign both_vld = i_a_vld && i_b_vld;
    // Ties select A, keeping the merge stable.
    assign sel_a    = DESC ? (i_a_data >= i_b_data) : (i_a_data <= i_b_data);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= BOTH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        o_a_rdy    = 1'b0;
        o_b_rdy    = 1'b0;
        case (state)
            BOTH: begin
                o_a_rdy = adv && both_vld && sel_a;
                o_b_rdy = adv && both_vld && !sel_a;
            end
            DRAIN_A: o_a_rdy = adv;
            DRAIN_B: o_b_rdy = adv;
            default: ;
        endcase

        a_hs = i_a_vld && o_a_rdy;
        b_hs = i_b_vld && o_b_rdy;

        case (state)
            BOTH: begin
                if (a_hs && i_a_last) begin
                    state_next = DRAIN_B;
                end else if (b_hs && i_b_last) begin
                    state_next = DRAIN_A;
                end
            end
            DRAIN_A: if (a_hs && i_a_last) state_next = BOTH;
            DRAIN_B: if (b_hs && i_b_last) state_next = BOTH;
            default: state_next = BOTH;
        endcase
    end

    // A packet's last only ends the merged packet when the other packet is
    // already exhausted, i.e. when it is consumed in a drain state.
    assign load_data = a_hs ? i_a_data : i_b_data;
    assign load_last = (state != BOTH) && (a_hs ? i_a_last : i_b_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_vld  <= 1'b0;
            o_data <= '0;
            o_last <= 1'b0;
        end else if (a_hs || b_hs) begin
            o_vld  <= 1'b1;
            o_data <= load_data;
            o_last <= load_last;
        end else if (i_rdy) begin
            o_vld  <= 1'b0;
        end
    end

    cm_merge_ord_chk #(
        .DWIDTH (DWIDTH),
        .DESC   (DESC)
    ) u_chk_a (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .hs    (a_hs),
        .data  (i_a_data),
        .last  (i_a_last),
        .viol  (viol_a)
    );

    cm_merge_ord_chk #(
        .DWIDTH (DWIDTH),
        .DESC   (DESC)
    ) u_chk_b (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .hs    (b_hs),
        .data  (i_b_data),
        .last  (i_b_last),
        .viol  (viol_b)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err <= 1'b0;
        end else if (viol_a || viol_b) begin
            o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cm_merge.sv
// tb_cm_merge: directed bench for cm_merge. Two instances (ascending and
// descending) share the stimulus; use_desc selects which one is driven and
// observed. Expected outputs, handshake sources and flags are hand-written.
module tb_cm_merge;

    logic       clk;
    logic       rst_n;
    logic       use_desc;
    logic       a_vld, b_vld, rdy;
    logic [7:0] a_data, b_data;
    logic       a_last, b_last;

    logic       asc_a_vld, asc_b_vld, desc_a_vld, desc_b_vld;
    logic       asc_a_rdy, asc_b_rdy, asc_vld, asc_last, asc_err;
    logic       desc_a_rdy, desc_b_rdy, desc_vld, desc_last, desc_err;
    logic [7:0] asc_data, desc_data;

    logic       m_a_rdy, m_b_rdy, m_vld, m_last;
    logic [7:0] m_data;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] qa_d[$];
    logic       qa_l[$];
    logic [7:0] qb_d[$];
    logic       qb_l[$];
    logic [7:0] exp_d[$];
    logic       exp_l[$];
    logic [1:0] exp_src[$];   // 2'b10 = A consumed, 2'b01 = B consumed
    logic       rdy_pat[$];

    assign asc_a_vld  = a_vld && !use_desc;
    assign asc_b_vld  = b_vld && !use_desc;
    assign desc_a_vld = a_vld && use_desc;
    assign desc_b_vld = b_vld && use_desc;

    assign m_a_rdy = use_desc ? desc_a_rdy : asc_a_rdy;
    assign m_b_rdy = use_desc ? desc_b_rdy : asc_b_rdy;
    assign m_vld   = use_desc ? desc_vld   : asc_vld;
    assign m_data  = use_desc ? desc_data  : asc_data;
    assign m_last  = use_desc ? desc_last  : asc_last;

    cm_merge #(.DWIDTH(8), .DESC(1'b0)) dut_asc (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_a_vld  (asc_a_vld),
        .o_a_rdy  (asc_a_rdy),
        .i_a_data (a_data),
        .i_a_last (a_last),
        .i_b_vld  (asc_b_vld),
        .o_b_rdy  (asc_b_rdy),
        .i_b_data (b_data),
        .i_b_last (b_last),
        .o_vld    (asc_vld),
        .i_rdy    (rdy),
        .o_data   (asc_data),
        .o_last   (asc_last),
        .o_err    (asc_err)
    );

    cm_merge #(.DWIDTH(8), .DESC(1'b1)) dut_desc (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_a_vld  (desc_a_vld),
        .o_a_rdy  (desc_a_rdy),
        .i_a_data (a_data),
        .i_a_last (a_last),
        .i_b_vld  (desc_b_vld),
        .o_b_rdy  (desc_b_rdy),
        .i_b_data (b_data),
        .i_b_last (b_last),
        .o_vld    (desc_vld),
        .i_rdy    (rdy),
        .o_data   (desc_data),
        .o_last   (desc_last),
        .o_err    (desc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_a(input logic [7:0] d, input logic l);
        qa_d.push_back(d);
        qa_l.push_back(l);
    endtask

    task automatic load_b(input logic [7:0] d, input logic l);
        qb_d.push_back(d);
        qb_l.push_back(l);
    endtask

    task automatic expect_out(input logic [7:0] d, input logic l, input logic [1:0] src);
        exp_d.push_back(d);
        exp_l.push_back(l);
        exp_src.push_back(src);
    endtask

    task automatic clear_all();
        qa_d.delete(); qa_l.delete(); qb_d.delete(); qb_l.delete();
        exp_d.delete(); exp_l.delete(); exp_src.delete();
    endtask

    // Drive queued packets cycle by cycle and check every handshake and
    // output beat. stop_after > 0 returns right after that many output beats,
    // before the next rising edge.
    task automatic run(input string tag, input int stop_after, input bit tp_check);
        int         cyc       = 0;
        int         nout      = 0;
        int         first_out = -1;
        int         last_out  = -1;
        int         pi        = 0;
        bit         stalled   = 0;
        bit         done      = 0;
        logic [7:0] held_d    = '0;
        logic       held_l    = 1'b0;
        logic       hs_a, hs_b;
        logic [7:0] dmy_d;
        logic       dmy_l;
        while (!done) begin
            @(negedge clk);
            a_vld  = qa_d.size() > 0;
            a_data = a_vld ? qa_d[0] : 8'h00;
            a_last = a_vld ? qa_l[0] : 1'b0;
            b_vld  = qb_d.size() > 0;
            b_data = b_vld ? qb_d[0] : 8'h00;
            b_last = b_vld ? qb_l[0] : 1'b0;
            rdy    = rdy_pat[pi % rdy_pat.size()];
            pi++;
            #1;
            if (stalled) begin
                chk({tag, " hold data"}, m_data, held_d);
                chk({tag, " hold last"}, m_last, held_l);
            end
            if (m_vld && !rdy) begin
                chk({tag, " stall rdy"}, {m_a_rdy, m_b_rdy}, 2'b00);
                held_d  = m_data;
                held_l  = m_last;
                stalled = 1;
            end else begin
                stalled = 0;
            end
            hs_a = a_vld && m_a_rdy;
            hs_b = b_vld && m_b_rdy;
            if (hs_a || hs_b) begin
                if (exp_src.size() == 0) chk({tag, " extra input"}, {hs_a, hs_b}, 2'b00);
                else chk({tag, " src"}, {hs_a, hs_b}, exp_src.pop_front());
            end
            if (m_vld && rdy) begin
                if (exp_d.size() == 0) begin
                    chk({tag, " extra output"}, {m_last, m_data}, 9'h000);
                end else begin
                    chk({tag, " data"}, m_data, exp_d.pop_front());
                    chk({tag, " last"}, m_last, exp_l.pop_front());
                end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                nout++;
                if (stop_after > 0 && nout == stop_after) return;
            end
            @(posedge clk);
            if (hs_a) begin dmy_d = qa_d.pop_front(); dmy_l = qa_l.pop_front(); end
            if (hs_b) begin dmy_d = qb_d.pop_front(); dmy_l = qb_l.pop_front(); end
            cyc++;
            if (exp_d.size() == 0 && exp_src.size() == 0) done = 1;
            if (cyc >= 200) begin
                chk({tag, " timeout left"}, exp_d.size(), 0);
                done = 1;
            end
        end
        @(negedge clk);
        a_vld = 1'b0;
        b_vld = 1'b0;
        rdy   = 1'b1;
        if (tp_check) begin
            chk({tag, " latency"}, first_out, 1);
            chk({tag, " beat span"}, last_out - first_out, nout - 1);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        use_desc = 1'b0;
        a_vld = 1'b1; a_data = 8'd1; a_last = 1'b0;
        b_vld = 1'b1; b_data = 8'd2; b_last = 1'b0;
        rdy = 1'b1;
        rdy_pat.push_back(1'b1);

        // Reset state, with both inputs presenting data
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst vld",   asc_vld,   0);
        chk("rst data",  asc_data,  0);
        chk("rst last",  asc_last,  0);
        chk("rst err",   asc_err,   0);
        chk("rst rdy",   {asc_a_rdy, asc_b_rdy}, 2'b00);
        chk("rst err d", desc_err,  0);
        a_vld = 1'b0;
        b_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Basic merge
        load_a(8'd1, 0); load_a(8'd4, 0); load_a(8'd7, 1);
        load_b(8'd2, 0); load_b(8'd3, 0); load_b(8'd9, 1);
        expect_out(8'd1, 0, 2'b10); expect_out(8'd2, 0, 2'b01);
        expect_out(8'd3, 0, 2'b01); expect_out(8'd4, 0, 2'b10);
        expect_out(8'd7, 0, 2'b10); expect_out(8'd9, 1, 2'b01);
        run("basic", 0, 1);

        // Tie goes to A
        load_a(8'd5, 1);
        load_b(8'd5, 0); load_b(8'd6, 1);
        expect_out(8'd5, 0, 2'b10); expect_out(8'd5, 0, 2'b01);
        expect_out(8'd6, 1, 2'b01);
        run("tie", 0, 1);

        // Unequal lengths, A drains after B is exhausted
        load_a(8'd10, 1);
        load_b(8'd1, 0); load_b(8'd2, 0); load_b(8'd3, 0); load_b(8'd4, 1);
        expect_out(8'd1, 0, 2'b01); expect_out(8'd2, 0, 2'b01);
        expect_out(8'd3, 0, 2'b01); expect_out(8'd4, 0, 2'b01);
        expect_out(8'd10, 1, 2'b10);
        run("drain", 0, 1);

        // Backpressure, ready pattern 1,0,0,1 repeating
        rdy_pat.delete();
        rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b0);
        rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b1);
        load_a(8'd1, 0); load_a(8'd4, 0); load_a(8'd7, 1);
        load_b(8'd2, 0); load_b(8'd3, 0); load_b(8'd9, 1);
        expect_out(8'd1, 0, 2'b10); expect_out(8'd2, 0, 2'b01);
        expect_out(8'd3, 0, 2'b01); expect_out(8'd4, 0, 2'b10);
        expect_out(8'd7, 0, 2'b10); expect_out(8'd9, 1, 2'b01);
        run("bp", 0, 0);
        chk("asc err clean", asc_err, 0);
        rdy_pat.delete();
        rdy_pat.push_back(1'b1);

        // Descending merge
        use_desc = 1'b1;
        load_a(8'd9, 0); load_a(8'd3, 1);
        load_b(8'd8, 0); load_b(8'd8, 1);
        expect_out(8'd9, 0, 2'b10); expect_out(8'd8, 0, 2'b01);
        expect_out(8'd8, 0, 2'b01); expect_out(8'd3, 1, 2'b10);
        run("desc", 0, 1);
        chk("desc err clean", desc_err, 0);

        // Descending order violation on A (2 then 5)
        load_a(8'd2, 0); load_a(8'd5, 1);
        load_b(8'd1, 1);
        expect_out(8'd2, 0, 2'b10); expect_out(8'd5, 0, 2'b10);
        expect_out(8'd1, 1, 2'b01);
        run("desc viol", 0, 0);
        chk("desc err set", desc_err, 1);
        repeat (3) @(negedge clk);
        chk("desc err sticky", desc_err, 1);

        // Reset in the middle of a packet
        use_desc = 1'b0;
        load_a(8'd1, 0); load_a(8'd3, 0); load_a(8'd5, 1);
        load_b(8'd2, 0); load_b(8'd4, 1);
        expect_out(8'd1, 0, 2'b10); expect_out(8'd2, 0, 2'b01);
        expect_out(8'd3, 0, 2'b10); expect_out(8'd4, 0, 2'b01);
        expect_out(8'd5, 1, 2'b10);
        run("mid", 2, 0);
        rst_n = 1'b0;
        #1;
        chk("mid rst vld",   asc_vld,  0);
        chk("mid rst last",  asc_last, 0);
        chk("mid rst rdy",   {asc_a_rdy, asc_b_rdy}, 2'b00);
        chk("mid rst err d", desc_err, 0);
        clear_all();
        a_vld = 1'b0;
        b_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh packets after reset; A starts below the pre-reset A value
        load_a(8'd0, 1);
        load_b(8'd1, 1);
        expect_out(8'd0, 0, 2'b10); expect_out(8'd1, 1, 2'b01);
        run("post rst", 0, 1);
        chk("post rst err", asc_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
